// File: rtl/mpx_lsu_pkg.sv
// MPX load/store unit shared definitions.
// Opcode constants, instruction field ranges and LSU FSM encodings.
package mpx_lsu_pkg;

  localparam int OPCODE_INST_R_HI = 31;
  localparam int OPCODE_INST_R_LO = 26;
  localparam int OPCODE_IMM_R_HI  = 15;
  localparam int OPCODE_IMM_R_LO  = 0;

  localparam logic [5:0] INSTR_I_LB  = 6'h20;
  localparam logic [5:0] INSTR_I_LH  = 6'h21;
  localparam logic [5:0] INSTR_I_LW  = 6'h23;
  localparam logic [5:0] INSTR_I_LBU = 6'h24;
  localparam logic [5:0] INSTR_I_LHU = 6'h25;
  localparam logic [5:0] INSTR_I_SB  = 6'h28;
  localparam logic [5:0] INSTR_I_SH  = 6'h29;
  localparam logic [5:0] INSTR_I_SW  = 6'h2B;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {INSTR_I_LB, INSTR_I_LH, INSTR_I_LW,
                      INSTR_I_LBU, INSTR_I_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {INSTR_I_SB, INSTR_I_SH, INSTR_I_SW};
  endfunction

endpackage

// File: rtl/mpx_lsu_align.sv
// MPX LSU lane steering: store replication/strobes and
// load byte/half extraction with sign or zero extension.
module mpx_lsu_align
  import mpx_lsu_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  input  logic [5:0]  ld_op,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wr_data = st_data;
    wr_strb = 4'b0000;
    unique case (1'b1)
      st_op == INSTR_I_SB: begin
        wr_data = {4{st_data[7:0]}};
        wr_strb = 4'b0001 << st_addr;
      end
      st_op == INSTR_I_SH: begin
        wr_data = {2{st_data[15:0]}};
        wr_strb = 4'b0011 << {st_addr[1], 1'b0};
      end
      st_op == INSTR_I_SW: begin
        wr_strb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_data[7:0];
    unique case (ld_addr)
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      2'd3:    ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
    ld_half = ld_addr[1] ? ld_data[31:16] : ld_data[15:0];
  end

  always_comb begin
    ld_value = ld_data;
    unique case (1'b1)
      ld_op == INSTR_I_LB:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      ld_op == INSTR_I_LBU: ld_value = {24'd0, ld_byte};
      ld_op == INSTR_I_LH:  ld_value = {{16{ld_half[15]}}, ld_half};
      ld_op == INSTR_I_LHU: ld_value = {16'd0, ld_half};
      default:              ld_value = ld_data;
    endcase
  end

endmodule

// File: rtl/mpx_lsu.sv
// MPX load/store stage: one MIPS-I data access per memory op.
// Define MPX_LSU_ALIGN_FAULT_EN to fault misaligned half/word ops.
module mpx_lsu
  import mpx_lsu_pkg::*;
#(
  parameter int MEM_ID_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                opcode_valid_i,
  input  logic [31:0]         opcode_opcode_i,
  input  logic [31:0]         opcode_pc_i,
  input  logic [31:0]         opcode_rs_operand_i,
  input  logic [31:0]         opcode_rt_operand_i,
  input  logic                hold_i,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_data_wr_o,
  output logic                mem_rd_o,
  output logic [3:0]          mem_wr_o,
  output logic [MEM_ID_W-1:0] mem_req_tag_o,
  input  logic                mem_accept_i,
  input  logic                mem_ack_i,
  input  logic [MEM_ID_W-1:0] mem_resp_tag_i,
  input  logic [31:0]         mem_data_rd_i,
  input  logic                mem_error_i,
  output logic                stall_o,
  output logic                writeback_valid_o,
  output logic [31:0]         writeback_value_o,
  output logic                fault_o,
  output logic [31:0]         fault_addr_o
);

  lsu_state_t state_q, state_d;

  logic [5:0]          op;
  logic [15:0]         imm;
  logic [31:0]         ea;
  logic                mem_op;
  logic                misalign;
  logic [5:0]          op_q;
  logic [31:0]         addr_q;
  logic [MEM_ID_W-1:0] tag_q;
  logic [MEM_ID_W-1:0] wait_tag;
  logic                accepted;
  logic                done;
  logic                capture;
  logic                issue;
  logic [31:0]         wr_data;
  logic [3:0]          wr_strb;
  logic [31:0]         ld_value;
  logic                unused_ok;

  assign op  = opcode_opcode_i[OPCODE_INST_R_HI:OPCODE_INST_R_LO];
  assign imm = opcode_opcode_i[OPCODE_IMM_R_HI:OPCODE_IMM_R_LO];
  assign ea  = opcode_rs_operand_i + {{16{imm[15]}}, imm};
  assign mem_op = is_load(op) | is_store(op);
  assign unused_ok = ^{opcode_pc_i, opcode_opcode_i[25:16]};

`ifdef MPX_LSU_ALIGN_FAULT_EN
  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      op == INSTR_I_LH,
      op == INSTR_I_LHU,
      op == INSTR_I_SH: misalign = ea[0];
      op == INSTR_I_LW,
      op == INSTR_I_SW: misalign = |ea[1:0];
      default:          misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // tag_q already advanced on accept; WAIT matches the previous tag
  assign wait_tag = tag_q - MEM_ID_W'(1);
  assign accepted = (state_q == LSU_REQ) & mem_accept_i;
  assign done = mem_ack_i &
    (((state_q == LSU_WAIT) & (mem_resp_tag_i == wait_tag)) |
     (accepted & (mem_resp_tag_i == tag_q)));

  assign stall_o = (state_q != LSU_IDLE) &
    ~((state_q == LSU_WAIT) & mem_ack_i &
      (mem_resp_tag_i == wait_tag));

  assign capture = opcode_valid_i & mem_op & ~hold_i & ~stall_o;
  assign issue   = capture & ~misalign;

  mpx_lsu_align u_align (
    .st_op    (op),
    .st_addr  (ea[1:0]),
    .st_data  (opcode_rt_operand_i),
    .ld_op    (op_q),
    .ld_addr  (addr_q[1:0]),
    .ld_data  (mem_data_rd_i),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .ld_value (ld_value)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE: if (issue) state_d = LSU_REQ;
      LSU_REQ:  if (accepted) state_d = done ? LSU_IDLE : LSU_WAIT;
      LSU_WAIT: if (done) state_d = issue ? LSU_REQ : LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= LSU_IDLE;
      op_q              <= '0;
      addr_q            <= '0;
      tag_q             <= '0;
      mem_addr_o        <= '0;
      mem_data_wr_o     <= '0;
      mem_rd_o          <= 1'b0;
      mem_wr_o          <= '0;
      writeback_valid_o <= 1'b0;
      writeback_value_o <= '0;
      fault_o           <= 1'b0;
      fault_addr_o      <= '0;
    end else begin
      state_q           <= state_d;
      writeback_valid_o <= 1'b0;
      fault_o           <= 1'b0;
      if (accepted) begin
        mem_rd_o <= 1'b0;
        mem_wr_o <= '0;
        tag_q    <= tag_q + MEM_ID_W'(1);
      end
      if (done) begin
        if (mem_error_i) begin
          fault_o      <= 1'b1;
          fault_addr_o <= addr_q;
        end else if (is_load(op_q)) begin
          writeback_valid_o <= 1'b1;
          writeback_value_o <= ld_value;
        end
      end
      if (capture) begin
        if (misalign) begin
          fault_o      <= 1'b1;
          fault_addr_o <= ea;
        end else begin
          op_q          <= op;
          addr_q        <= ea;
          mem_addr_o    <= {ea[31:2], 2'b00};
          mem_data_wr_o <= wr_data;
          mem_rd_o      <= is_load(op);
          mem_wr_o      <= is_store(op) ? wr_strb : 4'b0000;
        end
      end
    end
  end

  assign mem_req_tag_o = tag_q;

endmodule

// File: tb/tb_mpx_lsu.sv
// Directed scoreboard bench for mpx_lsu.
// Expected load results and faults are queued at drive time.
module tb_mpx_lsu;
  import mpx_lsu_pkg::*;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          opcode_valid_i;
  logic [31:0]   opcode_opcode_i;
  logic [31:0]   opcode_pc_i;
  logic [31:0]   opcode_rs_operand_i;
  logic [31:0]   opcode_rt_operand_i;
  logic          hold_i;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_data_wr_o;
  logic          mem_rd_o;
  logic [3:0]    mem_wr_o;
  logic [TW-1:0] mem_req_tag_o;
  logic          mem_accept_i;
  logic          mem_ack_i;
  logic [TW-1:0] mem_resp_tag_i;
  logic [31:0]   mem_data_rd_i;
  logic          mem_error_i;
  logic          stall_o;
  logic          writeback_valid_o;
  logic [31:0]   writeback_value_o;
  logic          fault_o;
  logic [31:0]   fault_addr_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wb_q[$];
  logic [31:0] fault_q[$];
  logic [TW-1:0] tb_tag = '0;

  always #5 clk = ~clk;

  mpx_lsu #(.MEM_ID_W(TW)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_pc_i         (opcode_pc_i),
    .opcode_rs_operand_i (opcode_rs_operand_i),
    .opcode_rt_operand_i (opcode_rt_operand_i),
    .hold_i              (hold_i),
    .mem_addr_o          (mem_addr_o),
    .mem_data_wr_o       (mem_data_wr_o),
    .mem_rd_o            (mem_rd_o),
    .mem_wr_o            (mem_wr_o),
    .mem_req_tag_o       (mem_req_tag_o),
    .mem_accept_i        (mem_accept_i),
    .mem_ack_i           (mem_ack_i),
    .mem_resp_tag_i      (mem_resp_tag_i),
    .mem_data_rd_i       (mem_data_rd_i),
    .mem_error_i         (mem_error_i),
    .stall_o             (stall_o),
    .writeback_valid_o   (writeback_valid_o),
    .writeback_value_o   (writeback_value_o),
    .fault_o             (fault_o),
    .fault_addr_o        (fault_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every pulse must match the head of its queue
  always @(negedge clk) begin
    if (writeback_valid_o) begin
      chk("wb_expected", 32'(wb_q.size() != 0), 32'd1);
      if (wb_q.size() != 0)
        chk("wb_value", writeback_value_o, wb_q.pop_front());
    end
    if (fault_o) begin
      chk("fault_expected", 32'(fault_q.size() != 0), 32'd1);
      if (fault_q.size() != 0)
        chk("fault_addr", fault_addr_o, fault_q.pop_front());
    end
  end

  function automatic logic [31:0] ins(input logic [5:0] op,
                                      input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic do_op(
    input logic [5:0]  op,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [15:0] imm,
    input int          acc_dly,
    input int          ack_dly,
    input bit          bad_ack,
    input logic [31:0] rdata,
    input bit          err,
    input logic [31:0] e_addr,
    input logic [31:0] e_wdata,
    input logic [3:0]  e_wr,
    input logic [31:0] e_val
  );
    bit ld;
    logic [31:0] ea;
    logic [TW-1:0] rtag;
    ld = is_load(op);
    ea = rs + {{16{imm[15]}}, imm};
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ins(op, imm);
    opcode_rs_operand_i = rs;
    opcode_rt_operand_i = rt;
    chk("issue_stall", 32'(stall_o), 32'd0);
    tick();
    opcode_valid_i = 1'b0;
    for (int i = 0; i <= acc_dly; i++) begin
      chk("req_addr", mem_addr_o, e_addr);
      chk("req_rd", 32'(mem_rd_o), 32'(ld));
      chk("req_wr", 32'(mem_wr_o), 32'(e_wr));
      chk("req_tag", 32'(mem_req_tag_o), 32'(tb_tag));
      chk("req_stall", 32'(stall_o), 32'd1);
      if (!ld) chk("req_data", mem_data_wr_o, e_wdata);
      if (i < acc_dly) tick();
    end
    rtag = tb_tag;
    mem_accept_i = 1'b1;
    mem_data_rd_i = rdata;
    mem_error_i = err;
    if (err) fault_q.push_back(ea);
    else if (ld) wb_q.push_back(e_val);
    if (ack_dly == 0) begin
      mem_ack_i = 1'b1;
      mem_resp_tag_i = rtag;
    end
    tick();
    tb_tag = tb_tag + 1'b1;
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    chk("req_drop_rd", 32'(mem_rd_o), 32'd0);
    chk("req_drop_wr", 32'(mem_wr_o), 32'd0);
    if (ack_dly > 0) begin
      for (int i = 1; i < ack_dly; i++) begin
        chk("wait_stall", 32'(stall_o), 32'd1);
        tick();
      end
      if (bad_ack) begin
        mem_ack_i = 1'b1;
        mem_resp_tag_i = rtag + 1'b1;
        #1;
        chk("badtag_stall", 32'(stall_o), 32'd1);
        tick();
        mem_ack_i = 1'b0;
      end
      mem_ack_i = 1'b1;
      mem_resp_tag_i = rtag;
      #1;
      chk("ack_stall", 32'(stall_o), 32'd0);
      tick();
      mem_ack_i = 1'b0;
    end
    mem_error_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    opcode_valid_i = 1'b0;
    opcode_opcode_i = '0;
    opcode_pc_i = 32'hBFC0_0000;
    opcode_rs_operand_i = '0;
    opcode_rt_operand_i = '0;
    hold_i = 1'b0;
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_resp_tag_i = '0;
    mem_data_rd_i = '0;
    mem_error_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_wr", 32'(mem_wr_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_tag", 32'(mem_req_tag_o), 32'd0);
    chk("rst_wbv", writeback_value_o, 32'd0);

    // LW, accept and ack together
    do_op(INSTR_I_LW, 32'h1000, 0, 16'h0004, 0, 0, 0,
          32'hDEADBEEF, 0, 32'h1004, 0, 4'b0000, 32'hDEADBEEF);
    chk("wb_hold", writeback_value_o, 32'hDEADBEEF);
    // LB / LBU at byte 3
    do_op(INSTR_I_LB, 32'h2003, 0, 16'h0000, 0, 0, 0,
          32'h80FFFFFF, 0, 32'h2000, 0, 4'b0000, 32'hFFFFFF80);
    do_op(INSTR_I_LBU, 32'h2003, 0, 16'h0000, 0, 0, 0,
          32'h80FFFFFF, 0, 32'h2000, 0, 4'b0000, 32'h00000080);
    // stores
    do_op(INSTR_I_SH, 32'h3002, 32'h1234ABCD, 16'h0000, 0, 1, 0,
          0, 0, 32'h3000, 32'hABCDABCD, 4'b1100, 0);
    do_op(INSTR_I_SB, 32'h3001, 32'h000000A5, 16'h0000, 1, 1, 0,
          0, 0, 32'h3000, 32'hA5A5A5A5, 4'b0010, 0);
    do_op(INSTR_I_SW, 32'h3010, 32'h01020304, 16'hFFF4, 0, 0, 0,
          0, 0, 32'h3004, 32'h01020304, 4'b1111, 0);
    // slow bus with negative offset
    do_op(INSTR_I_LW, 32'h5000, 0, 16'hFFFC, 3, 5, 0,
          32'hCAFEF00D, 0, 32'h4FFC, 0, 4'b0000, 32'hCAFEF00D);
    // mismatched tag ignored, halfword loads
    do_op(INSTR_I_LHU, 32'h6000, 0, 16'h0002, 0, 2, 1,
          32'h89AB0000, 0, 32'h6000, 0, 4'b0000, 32'h000089AB);
    do_op(INSTR_I_LH, 32'h6002, 0, 16'h0000, 0, 1, 0,
          32'h89AB1234, 0, 32'h6000, 0, 4'b0000, 32'hFFFF89AB);
    do_op(INSTR_I_LH, 32'h6000, 0, 16'h0000, 0, 1, 0,
          32'h89AB1234, 0, 32'h6000, 0, 4'b0000, 32'h00001234);
    // bus error: fault, no writeback
    do_op(INSTR_I_LW, 32'h7008, 0, 16'h0000, 0, 2, 0,
          32'h55555555, 1, 32'h7008, 0, 4'b0000, 0);

    // hold blocks issue
    hold_i = 1'b1;
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ins(INSTR_I_LW, 16'h0);
    opcode_rs_operand_i = 32'h9000;
    tick();
    chk("hold_rd", 32'(mem_rd_o), 32'd0);
    chk("hold_stall", 32'(stall_o), 32'd0);
    hold_i = 1'b0;
    opcode_valid_i = 1'b0;
    // non-memory opcode ignored
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ins(6'h08, 16'h0010);
    tick();
    opcode_valid_i = 1'b0;
    chk("alu_rd", 32'(mem_rd_o), 32'd0);
    chk("alu_stall", 32'(stall_o), 32'd0);

    // reset while waiting, then a late ack
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ins(INSTR_I_LW, 16'h0);
    opcode_rs_operand_i = 32'h8000;
    tick();
    opcode_valid_i = 1'b0;
    mem_accept_i = 1'b1;
    tick();
    mem_accept_i = 1'b0;
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tb_tag = '0;
    chk("mrst_addr", mem_addr_o, 32'd0);
    chk("mrst_rd", 32'(mem_rd_o), 32'd0);
    chk("mrst_data", mem_data_wr_o, 32'd0);
    chk("mrst_tag", 32'(mem_req_tag_o), 32'd0);
    chk("mrst_stall", 32'(stall_o), 32'd0);
    chk("mrst_wbv", writeback_value_o, 32'd0);
    chk("mrst_faddr", fault_addr_o, 32'd0);
    mem_ack_i = 1'b1;
    mem_resp_tag_i = '0;
    mem_data_rd_i = 32'hBAADF00D;
    tick();
    mem_ack_i = 1'b0;
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    tick();
    chk("late_ack_wbv", writeback_value_o, 32'd0);

    // misaligned word load
`ifdef MPX_LSU_ALIGN_FAULT_EN
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ins(INSTR_I_LW, 16'h0001);
    opcode_rs_operand_i = 32'h4000;
    fault_q.push_back(32'h4001);
    tick();
    opcode_valid_i = 1'b0;
    chk("mis_rd", 32'(mem_rd_o), 32'd0);
    chk("mis_stall", 32'(stall_o), 32'd0);
    tick();
`else
    do_op(INSTR_I_LW, 32'h4000, 0, 16'h0001, 0, 0, 0,
          32'h11223344, 0, 32'h4000, 0, 4'b0000, 32'h11223344);
`endif
    // recovery after reset starts again from tag 0
    do_op(INSTR_I_LW, 32'hA000, 0, 16'h0000, 0, 0, 0,
          32'h0BADCAFE, 0, 32'hA000, 0, 4'b0000, 32'h0BADCAFE);

    tick();
    tick();
    chk("wb_q_drained", wb_q.size(), 32'd0);
    chk("fault_q_drained", fault_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
